memwb_skid_pipe: RTL and testbench

Parametrised MEM/WB pipeline stage for the RV32I pipeline; successor to the plain free-running MEM/WB register. It carries the writeback payload (reg-write enable, result-select, ALU result, load data, PC+4, instruction, PC) through a two-entry skid buffer. It adds valid/ready flow control, synchronous flush, asynchronous reset and bubble-safe `reg_write`. It sits between the memory stage and the writeback mux/register file, and lets WB stall without a combinational ready path back into MEM.

---
 rtl/memwb_skid_pipe.sv | 187 ++++++++++++++++++
 tb/tb_memwb_skid_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_skid_pipe.sv
// -----------------------------------------------------------------------------
// memwb_skid_pipe
//
// MEM/WB pipeline stage for the RV32I pipeline, built around a two-entry skid
// buffer. The head entry M drives the writeback outputs and the skid entry S
// catches one extra payload. This lets WB stall without a combinational ready
// path back into the memory stage.
//
// Parameters
//   XLEN      : width of the alu_res / wrap_load / next_sel_addr / pre_address
//               fields (32 or 64)
//   NOP_INSN  : instruction presented after reset (addi x0,x0,0)
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid / in_ready    : MEM-side handshake (in_ready is registered)
//   flush                  : synchronous kill of every held entry
//   *_in                   : writeback payload from the memory stage
//   out_valid / out_ready  : WB-side handshake
//   reg_write_out          : register-file write enable, forced low on bubbles
//   *_out                  : head-entry payload fields
//   stall_cycles,
//   flush_count            : statistics counters, present only when the
//                            MEMWB_PIPE_STATS_EN macro is defined
// -----------------------------------------------------------------------------
module memwb_skid_pipe #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            reg_write_in,
    input  logic [1:0]      mem_reg_in,
    input  logic [XLEN-1:0] alu_res_in,
    input  logic [XLEN-1:0] wrap_load_in,
    input  logic [XLEN-1:0] next_sel_addr_in,
    input  logic [XLEN-1:0] pre_address_in,
    input  logic [31:0]     instruction_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            reg_write_out,
    output logic [1:0]      mem_reg_out,
    output logic [XLEN-1:0] alu_res_out,
    output logic [XLEN-1:0] wrap_load_out,
    output logic [XLEN-1:0] next_sel_addr_out,
    output logic [XLEN-1:0] pre_address_out,
    output logic [31:0]     instruction_out
`ifdef MEMWB_PIPE_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [15:0]     flush_count
`endif
);

    // Packed payload layout: {reg_write, mem_reg, alu, wrap, next_sel, pre, insn}
    localparam int PW = 1 + 2 + 4 * XLEN + 32;
    localparam logic [PW-1:0] RST_PAY = {{(PW-32){1'b0}}, NOP_INSN};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   m_q, m_d;
    logic [PW-1:0]   s_q, s_d;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            reg_write_q;
    logic [PW-1:0]   in_pay_s;
    logic            push_s;
    logic            pop_s;
    logic            m_rw_unused_s;

    assign in_pay_s = {reg_write_in, mem_reg_in, alu_res_in, wrap_load_in,
                       next_sel_addr_in, pre_address_in, instruction_in};

    // Handshakes use only registered flags, so out_ready never reaches in_ready.
    assign push_s = in_valid & in_ready_q;
    assign pop_s  = out_valid_q & out_ready;

    // Next-state and payload steering for the two-entry skid buffer.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            // Flush wins: any same-cycle push is dropped; payloads stay stale.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d = ST_ONE;
                        m_d     = in_pay_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && !pop_s) begin
                        state_d = ST_FULL;
                        s_d     = in_pay_s;
                    end else if (push_s && pop_s) begin
                        // Head replaced in place: no bubble between entries.
                        state_d = ST_ONE;
                        m_d     = in_pay_s;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can change state.
                    if (pop_s) begin
                        state_d = ST_ONE;
                        m_d     = s_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, payload and registered handshake/qualifier flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            m_q         <= RST_PAY;
            s_q         <= RST_PAY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            reg_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_FULL);
            // Bubble-safe write enable: a stale head never writes the regfile.
            reg_write_q <= m_d[PW-1] & (state_d != ST_EMPTY);
        end
    end

    assign out_valid     = out_valid_q;
    assign in_ready      = in_ready_q;
    assign reg_write_out = reg_write_q;
    assign {m_rw_unused_s, mem_reg_out, alu_res_out, wrap_load_out,
            next_sel_addr_out, pre_address_out, instruction_out} = m_q;

`ifdef MEMWB_PIPE_STATS_EN
    logic [31:0] stall_q;
    logic [15:0] flush_cnt_q;

    // Saturating statistics counters; flush does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q     <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end else begin
                stall_q <= stall_q;
            end
            if (flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_memwb_skid_pipe.sv
module tb_memwb_skid_pipe;

    typedef struct packed {
        logic        rw;
        logic [1:0]  mr;
        logic [31:0] alu;
        logic [31:0] wrap;
        logic [31:0] nsa;
        logic [31:0] pre;
        logic [31:0] insn;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        reg_write_in = 1'b0;
    logic [1:0]  mem_reg_in = 2'd0;
    logic [31:0] alu_res_in = 32'd0;
    logic [31:0] wrap_load_in = 32'd0;
    logic [31:0] next_sel_addr_in = 32'd0;
    logic [31:0] pre_address_in = 32'd0;
    logic [31:0] instruction_in = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        reg_write_out;
    logic [1:0]  mem_reg_out;
    logic [31:0] alu_res_out;
    logic [31:0] wrap_load_out;
    logic [31:0] next_sel_addr_out;
    logic [31:0] pre_address_out;
    logic [31:0] instruction_out;

    // 64-bit instance signals
    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [63:0] alu64_in = 64'd0;
    logic        out_valid64;
    logic        out_ready64 = 1'b1;
    logic        reg_write_out64;
    logic [1:0]  mem_reg_out64;
    logic [63:0] alu64_out;
    logic [63:0] wrap64_out;
    logic [63:0] nsa64_out;
    logic [63:0] pre64_out;
    logic [31:0] insn64_out;

`ifdef MEMWB_PIPE_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic [31:0] stall_cycles64;
    logic [15:0] flush_count64;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    pay_t q[$];
    int   popped_val[$];
    int   popped_cyc[$];
    int   sz;
    pay_t h;
    int   t0;

    memwb_skid_pipe #(.XLEN(32), .NOP_INSN(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .reg_write_in(reg_write_in), .mem_reg_in(mem_reg_in),
        .alu_res_in(alu_res_in), .wrap_load_in(wrap_load_in),
        .next_sel_addr_in(next_sel_addr_in), .pre_address_in(pre_address_in),
        .instruction_in(instruction_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_write_out(reg_write_out), .mem_reg_out(mem_reg_out),
        .alu_res_out(alu_res_out), .wrap_load_out(wrap_load_out),
        .next_sel_addr_out(next_sel_addr_out), .pre_address_out(pre_address_out),
        .instruction_out(instruction_out)
`ifdef MEMWB_PIPE_STATS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    memwb_skid_pipe #(.XLEN(64), .NOP_INSN(32'h0000_0013)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_ready(in_ready64), .flush(1'b0),
        .reg_write_in(1'b1), .mem_reg_in(2'd1),
        .alu_res_in(alu64_in), .wrap_load_in(64'd0),
        .next_sel_addr_in(64'd0), .pre_address_in(64'd0),
        .instruction_in(32'h0000_0033),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .reg_write_out(reg_write_out64), .mem_reg_out(mem_reg_out64),
        .alu_res_out(alu64_out), .wrap_load_out(wrap64_out),
        .next_sel_addr_out(nsa64_out), .pre_address_out(pre64_out),
        .instruction_out(insn64_out)
`ifdef MEMWB_PIPE_STATS_EN
        , .stall_cycles(stall_cycles64), .flush_count(flush_count64)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge; side fields follow alu.
    task automatic step(input logic v, input logic [31:0] a, input logic rw,
                        input logic fl, input logic ordy);
        @(negedge clk);
        in_valid         = v;
        alu_res_in       = a;
        wrap_load_in     = a ^ 32'h5A5A_5A5A;
        next_sel_addr_in = a + 32'd4;
        pre_address_in   = {a[29:0], 2'b00};
        instruction_in   = {a[19:0], 12'h013};
        mem_reg_in       = a[1:0];
        reg_write_in     = rw;
        flush            = fl;
        out_ready        = ordy;
    endtask

    // Monitor / scoreboard: model occupancy, compare head, then apply transfers.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            q.delete();
        end else begin
            sz = q.size();
            chk("out_valid", {63'd0, out_valid}, {63'd0, sz != 0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, sz < 2});
            if (sz != 0) begin
                h = q[0];
                chk("alu_res_out", {32'd0, alu_res_out}, {32'd0, h.alu});
                chk("wrap_load_out", {32'd0, wrap_load_out}, {32'd0, h.wrap});
                chk("next_sel_addr_out", {32'd0, next_sel_addr_out}, {32'd0, h.nsa});
                chk("pre_address_out", {32'd0, pre_address_out}, {32'd0, h.pre});
                chk("instruction_out", {32'd0, instruction_out}, {32'd0, h.insn});
                chk("mem_reg_out", {62'd0, mem_reg_out}, {62'd0, h.mr});
                chk("reg_write_out", {63'd0, reg_write_out}, {63'd0, h.rw});
            end else begin
                chk("reg_write_out_bubble", {63'd0, reg_write_out}, 64'd0);
            end
            if (sz != 0 && out_ready) begin
                popped_val.push_back(int'(q[0].alu));
                popped_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && sz < 2) begin
                q.push_back('{rw: reg_write_in, mr: mem_reg_in, alu: alu_res_in,
                              wrap: wrap_load_in, nsa: next_sel_addr_in,
                              pre: pre_address_in, insn: instruction_in});
            end
        end
    end

    initial begin
        // Reset values while rst is held across a rising edge
        @(posedge clk);
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_reg_write_out", {63'd0, reg_write_out}, 64'd0);
        chk("rst_instruction_out", {32'd0, instruction_out}, 64'h0000_0013);
        chk("rst_alu_res_out", {32'd0, alu_res_out}, 64'd0);
        chk("rst_mem_reg_out", {62'd0, mem_reg_out}, 64'd0);
        chk("rst_insn64", {32'd0, insn64_out}, 64'h0000_0013);
`ifdef MEMWB_PIPE_STATS_EN
        chk("rst_stall_cycles", {32'd0, stall_cycles}, 64'd0);
        chk("rst_flush_count", {48'd0, flush_count}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

        // Streaming: 1..8 back to back with out_ready high
        popped_val.delete();
        popped_cyc.delete();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, i, 1'b1, 1'b0, 1'b1);
            if (i == 1) t0 = cyc;
        end
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("stream_count", 64'(popped_val.size()), 64'd8);
        for (int i = 0; i < 8 && i < popped_val.size(); i++) begin
            chk("stream_value", 64'(popped_val[i]), 64'(i + 1));
            chk("stream_cycle", 64'(popped_cyc[i]), 64'(t0 + 1 + i));
        end

        // Backpressure: A, B, C with out_ready low
        popped_val.delete();
        popped_cyc.delete();
        step(1'b1, 32'd11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd13, 1'b1, 1'b0, 1'b0);
        #3;
        chk("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
        chk("bp_head_A", {32'd0, alu_res_out}, 64'd11);
        step(1'b1, 32'd13, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'd13, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("bp_count", 64'(popped_val.size()), 64'd3);
        for (int i = 0; i < 3 && i < popped_val.size(); i++) begin
            chk("bp_order", 64'(popped_val[i]), 64'(11 + i));
        end
`ifdef MEMWB_PIPE_STATS_EN
        chk("bp_stall_cycles", {32'd0, stall_cycles}, 64'd2);
`endif

        // Flush while FULL with a concurrent push of D
        popped_val.delete();
        step(1'b1, 32'd21, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd22, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd23, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_reg_write_out", {63'd0, reg_write_out}, 64'd0);
`ifdef MEMWB_PIPE_STATS_EN
        chk("flush_count", {48'd0, flush_count}, 64'd1);
`endif
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("flush_nothing_popped", 64'(popped_val.size()), 64'd0);

        // Bubble safety
        step(1'b1, 32'd31, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("bubble_rw_high", {63'd0, reg_write_out}, 64'd1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("bubble_rw_low", {63'd0, reg_write_out}, 64'd0);
        chk("bubble_alu_kept", {32'd0, alu_res_out}, 64'd31);
        chk("bubble_out_valid", {63'd0, out_valid}, 64'd0);

        // XLEN=64 data path
        @(negedge clk);
        in_valid64 = 1'b1;
        alu64_in   = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        in_valid64 = 1'b0;
        #3;
        chk("x64_out_valid", {63'd0, out_valid64}, 64'd1);
        chk("x64_alu_res_out", alu64_out, 64'hDEAD_BEEF_0123_4567);

        // Asynchronous reset mid-stream while FULL
        step(1'b1, 32'd41, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd42, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd43, 1'b1, 1'b0, 1'b0);
        #3;
        chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_instruction_out", {32'd0, instruction_out}, 64'h0000_0013);
        chk("arst_reg_write_out", {63'd0, reg_write_out}, 64'd0);
        chk("arst_alu_res_out", {32'd0, alu_res_out}, 64'd0);
`ifdef MEMWB_PIPE_STATS_EN
        chk("arst_stall_cycles", {32'd0, stall_cycles}, 64'd0);
        chk("arst_flush_count", {48'd0, flush_count}, 64'd0);
`endif
        @(negedge clk);
        step(1'b1, 32'd51, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_alu", {32'd0, alu_res_out}, 64'd51);
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
